// File: rtl/pixel_feed_if.sv
// FIFO-side bus of pixel_feed: FWFT head word, empty flag and the pop strobe.
// The pixel_feed side is the master (it decides when to pop); the FIFO is the slave.
interface pixel_feed_if;
  logic [24:0] fifo_rdata;  // [24] start-of-frame tag, [23:0] RGB
  logic        fifo_empty;
  logic        fifo_read;

  modport master (input fifo_rdata, input fifo_empty, output fifo_read);
  modport slave  (output fifo_rdata, output fifo_empty, input fifo_read);
endinterface

// File: rtl/pixel_feed.sv
// pixel_feed: pulls 24-bit pixels from a FWFT frame FIFO and presents them in
// step with the raster timing, locking to frames on the SOF tag and falling
// back to SEEK on underflow, misalignment or a short frame.
// Optional build macro PIXEL_FEED_STATS_EN enables the underflow/resync
// event counters; without it both count ports read 16'h0.
//
// state | meaning
// SEEK  | discarding FIFO words until the head carries the SOF tag
// ARMED | SOF at the head, waiting for the next VS falling edge
// RUN   | locked; one pixel popped per active cycle
module pixel_feed #(
  parameter int unsigned HDISP         = 800,
  parameter int unsigned VDISP         = 480,
  parameter logic [23:0] UNDERFLOW_RGB = 24'h0000FF
) (
  input  logic         pixel_clk,
  input  logic         pixel_rst,
  input  logic         hs_in,
  input  logic         vs_in,
  input  logic         blank_in,
  pixel_feed_if.master fifo,
  output logic         hs_out,
  output logic         vs_out,
  output logic         blank_out,
  output logic [23:0]  rgb_out,
  output logic         locked,
  output logic [15:0]  underflow_cnt,
  output logic [15:0]  resync_cnt
);

  localparam int unsigned NPIX = HDISP * VDISP;
  localparam int unsigned PW   = $clog2(NPIX + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);

  typedef enum logic [1:0] {SEEK, ARMED, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          locked_q, locked_d;
  logic          pop, head_ok, head_sof, vs_fall;

  // Next-state, pop decision and registered-output inputs.
  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    pop      = 1'b0;
    hs_d     = hs_in;
    vs_d     = vs_in;
    blank_d  = blank_in;
    rgb_d    = blank_in ? UNDERFLOW_RGB : 24'h0;
    head_ok  = !fifo.fifo_empty;
    head_sof = head_ok && fifo.fifo_rdata[24];
    // vs_q doubles as the previous-cycle VS used for edge detection
    vs_fall  = !vs_in && vs_q;

    unique case (state_q)
      SEEK: begin
        pop = head_ok && !head_sof;
        if (head_sof) state_d = ARMED;
      end
      ARMED: begin
        if (head_ok && !head_sof) begin
          state_d = SEEK;
        end else if (vs_fall && head_sof) begin
          state_d = RUN;
          pix_d   = '0;
        end
      end
      RUN: begin
        if (blank_in && !head_ok) begin
          state_d = SEEK;
        end else if (blank_in && head_sof && pix_q != '0) begin
          state_d = SEEK;
        end else begin
          if (blank_in) begin
            pop   = 1'b1;
            rgb_d = fifo.fifo_rdata[23:0];
            if (pix_q == PIX_LAST) begin
              pix_d   = '0;
              state_d = ARMED;
            end else begin
              pix_d = pix_q + PW'(1);
            end
          end
          // short frame: a new VS arrived before the frame was consumed
          if (vs_fall && pix_q != '0) state_d = SEEK;
        end
      end
      default: state_d = SEEK;
    endcase

    locked_d = (state_d == RUN);
  end

  // Pop is gated by reset so nothing is consumed while held in reset.
  assign fifo.fifo_read = pop && !pixel_rst;

  // State and registered outputs.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q  <= SEEK;
      pix_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      rgb_q    <= 24'h0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      rgb_q    <= rgb_d;
      locked_q <= locked_d;
    end
  end

  assign hs_out    = hs_q;
  assign vs_out    = vs_q;
  assign blank_out = blank_q;
  assign rgb_out   = rgb_q;
  assign locked    = locked_q;

`ifdef PIXEL_FEED_STATS_EN
  logic [15:0] uf_cnt_q, uf_cnt_d, rs_cnt_q, rs_cnt_d;
  logic        uf_evt, rs_evt;

  // Every exit from RUN to SEEK is a resync; underflow is the empty-head case.
  always_comb begin
    uf_evt   = (state_q == RUN) && blank_in && !head_ok;
    rs_evt   = (state_q == RUN) && (state_d == SEEK);
    uf_cnt_d = (uf_evt && uf_cnt_q != 16'hFFFF) ? uf_cnt_q + 16'd1 : uf_cnt_q;
    rs_cnt_d = (rs_evt && rs_cnt_q != 16'hFFFF) ? rs_cnt_q + 16'd1 : rs_cnt_q;
  end

  // Saturating event counters.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      uf_cnt_q <= 16'h0;
      rs_cnt_q <= 16'h0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
      rs_cnt_q <= rs_cnt_d;
    end
  end

  assign underflow_cnt = uf_cnt_q;
  assign resync_cnt    = rs_cnt_q;
`else
  assign underflow_cnt = 16'h0;
  assign resync_cnt    = 16'h0;
`endif

endmodule

// File: tb/tb_pixel_feed.sv
// Bench for pixel_feed with an 8x4 raster (12 cycles/line, 6 lines/frame).
// The bench owns the FIFO (a queue), a frame-level reference model with its own
// copy of the FIFO contents, and a scoreboard drained by a separate monitor.
module tb_pixel_feed;
  localparam int HD = 8, VD = 4, NPIX = HD * VD;
  localparam int HTOT = 12, VTOT = 6;
  localparam logic [23:0] UF = 24'h0000FF;
`ifdef PIXEL_FEED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        hs_in, vs_in, blank_in;
  logic        hs_out, vs_out, blank_out, locked;
  logic [23:0] rgb_out;
  logic [15:0] underflow_cnt, resync_cnt;

  pixel_feed_if bus();

  pixel_feed #(.HDISP(HD), .VDISP(VD), .UNDERFLOW_RGB(UF)) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .fifo(bus),
    .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out),
    .rgb_out(rgb_out), .locked(locked),
    .underflow_cnt(underflow_cnt), .resync_cnt(resync_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic        hs, vs, blank;
    logic [23:0] rgb;
    logic        lck;
    logic [15:0] ucnt, rcnt;
  } exp_t;

  exp_t        sb[$];
  logic [24:0] dq[$];   // words visible to the DUT
  logic [24:0] mq[$];   // the model's own view of the same FIFO
  int n_checks = 0, n_pass = 0;
  int h = 0, v = 0;
  bit s5_win = 1'b0;
  int n_pops = 0;

  // model: 0 hunting for SOF, 1 holding SOF waiting for VS, 2 showing a frame
  localparam int M_HUNT = 0, M_WAIT = 1, M_SHOW = 2;
  int mode, m_pos, m_uf, m_rs;
  bit m_vsp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat16(input int x);
    return (x >= 65535) ? 65535 : x + 1;
  endfunction

  task automatic model_reset();
    mode = M_HUNT; m_pos = 0; m_uf = 0; m_rs = 0; m_vsp = 1'b1;
  endtask

  // One pixel period of the reference behaviour.
  task automatic model_step(input bit hs, input bit vs, input bit blank,
                            output bit pop, output exp_t e);
    bit have, sof, fall, fault;
    have  = mq.size() > 0;
    sof   = have && mq[0][24];
    fall  = !vs && m_vsp;
    fault = 1'b0;
    pop   = 1'b0;
    e.rgb = blank ? UF : 24'h0;
    case (mode)
      M_HUNT: if (have) begin
        if (sof) mode = M_WAIT; else pop = 1'b1;
      end
      M_WAIT: begin
        if (have && !sof) mode = M_HUNT;
        else if (fall && sof) begin mode = M_SHOW; m_pos = 0; end
      end
      default: begin
        if (blank && !have) begin
          m_uf = sat16(m_uf); m_rs = sat16(m_rs); mode = M_HUNT; fault = 1'b1;
        end else if (blank && sof && m_pos != 0) begin
          m_rs = sat16(m_rs); mode = M_HUNT; fault = 1'b1;
        end else if (blank) begin
          pop = 1'b1; e.rgb = mq[0][23:0];
        end
        if (!fault && fall && m_pos != 0) begin
          m_rs = sat16(m_rs); mode = M_HUNT;
        end else if (pop) begin
          m_pos++;
          if (m_pos == NPIX) begin m_pos = 0; mode = M_WAIT; end
        end
      end
    endcase
    if (pop) void'(mq.pop_front());
    m_vsp   = vs;
    e.hs    = hs;
    e.vs    = vs;
    e.blank = blank;
    e.lck   = (mode == M_SHOW);
    e.ucnt  = STATS ? 16'(m_uf) : 16'h0;
    e.rcnt  = STATS ? 16'(m_rs) : 16'h0;
  endtask

  task automatic push_word(input logic [24:0] w);
    dq.push_back(w);
    mq.push_back(w);
  endtask

  task automatic push_frame(input int n, input bit seq);
    for (int i = 0; i < n; i++)
      push_word({(i == 0), seq ? 24'(i) : 24'($urandom)});
  endtask

  task automatic push_garbage(input int n);
    for (int i = 0; i < n; i++) push_word({1'b0, 24'($urandom)});
  endtask

  // Drive one raster cycle, log the expected response, check the pop strobe.
  task automatic cycle();
    bit   mpop, blk, rd;
    exp_t e;
    @(negedge pixel_clk);
    blk      = (h < HD) && (v < VD);
    blank_in = blk;
    hs_in    = !(h >= 9 && h < 11);
    vs_in    = !(v == 4);
    bus.fifo_empty = (dq.size() == 0);
    bus.fifo_rdata = (dq.size() == 0) ? 25'h0 : dq[0];
    model_step(hs_in, vs_in, blk, mpop, e);
    sb.push_back(e);
    #1;
    rd = bus.fifo_read;
    chk("fifo_read", rd, mpop);
    if (s5_win && !blk) chk("read_in_blank", rd, 1'b0);
    if (s5_win && rd) n_pops++;
    if (rd && dq.size() > 0) void'(dq.pop_front());
    h++;
    if (h == HTOT) begin h = 0; v = (v + 1) % VTOT; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: compares registered outputs against the scoreboard after each edge.
  exp_t mon_e;
  always begin
    @(posedge pixel_clk);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("hs_out", hs_out, mon_e.hs);
      chk("vs_out", vs_out, mon_e.vs);
      chk("blank_out", blank_out, mon_e.blank);
      chk("rgb_out", rgb_out, mon_e.rgb);
      chk("locked", locked, mon_e.lck);
      chk("underflow_cnt", underflow_cnt, mon_e.ucnt);
      chk("resync_cnt", resync_cnt, mon_e.rcnt);
    end
  end

  task automatic reset_value_checks(input string tag);
    chk({tag, "_hs"}, hs_out, 1'b1);
    chk({tag, "_vs"}, vs_out, 1'b1);
    chk({tag, "_blank"}, blank_out, 1'b0);
    chk({tag, "_rgb"}, rgb_out, 24'h0);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_ucnt"}, underflow_cnt, 16'h0);
    chk({tag, "_rcnt"}, resync_cnt, 16'h0);
    chk({tag, "_fifo_read"}, bus.fifo_read, 1'b0);
  endtask

  initial begin
    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.fifo_rdata = 25'h0000123;   // untagged head would be popped if not in reset
    model_reset();
    repeat (2) @(negedge pixel_clk);
    #1;
    reset_value_checks("por");
    @(negedge pixel_clk);
    pixel_rst = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = 25'h0;

    // 3 untagged words, then a frame valued 0..31
    push_garbage(3);
    push_frame(NPIX, 1'b1);
    run(72);
    run(72);
    chk("armed_after_frame", locked, 1'b0);

    // several back-to-back frames with the FIFO never running dry
    push_garbage($urandom_range(0, 2));
    for (int f = 0; f < 4; f++) push_frame(NPIX, 1'b0);
    run(72);
    s5_win = 1'b1; n_pops = 0;
    run(3 * 72);
    s5_win = 1'b0;
    chk("b2b_pops", n_pops, NPIX * 3);
    chk("b2b_ucnt", underflow_cnt, 16'h0);
    chk("b2b_rcnt", resync_cnt, 16'h0);
    run(72);

    // short frame: underflow at pixel 20, then a good frame
    push_garbage($urandom_range(0, 2));
    push_frame(20, 1'b0);
    run(72);
    run(40);
    push_frame(NPIX, 1'b0);
    run(32);
    chk("uf_ucnt", underflow_cnt, STATS ? 16'd1 : 16'd0);
    chk("uf_rcnt", resync_cnt, STATS ? 16'd1 : 16'd0);
    run(72);

    // SOF arrives at pixel 10: misalignment, tagged frame shown next
    push_garbage($urandom_range(0, 2));
    push_frame(10, 1'b0);
    push_frame(NPIX, 1'b0);
    run(72);
    run(72);
    chk("mis_ucnt", underflow_cnt, STATS ? 16'd1 : 16'd0);
    chk("mis_rcnt", resync_cnt, STATS ? 16'd2 : 16'd0);
    run(72);

    // reset pulse in the middle of a displayed frame
    push_frame(NPIX, 1'b0);
    run(72);
    run(30);
    chk("locked_before_rst", locked, 1'b1);
    @(negedge pixel_clk);
    pixel_rst = 1'b1;
    #1;
    reset_value_checks("mid_rst");
    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = 25'h0;
    dq.delete();
    mq.delete();
    model_reset();
    @(negedge pixel_clk);
    pixel_rst = 1'b0;
    #1;
    chk("locked_after_rst", locked, 1'b0);
    push_garbage(2);
    push_frame(NPIX, 1'b0);
    run(2 * 72 + 30);

    @(posedge pixel_clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
